// File: rtl/regfile_2r1w_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_ctrl
//   2**N x W register file with one synchronous write port and two
//   independently enabled read ports (A, B). Each read port decodes its
//   address to a one-hot select. The read data, the one-hot select and the
//   valid flag are registered, so the read latency is one cycle.
//   A read of the address being written in the same cycle returns the new
//   write data (bypass). When ZERO_REG is set, register 0 reads as zero and
//   writes to it are discarded.
//
// Ports
//   Clk       in   rising-edge clock
//   Rst_n     in   asynchronous active-low reset (clears registers and outputs)
//   W_adr     in   [N-1:0] write address
//   W_ena     in   write enable
//   W_data    in   [W-1:0] write data
//   Ra_adr    in   [N-1:0] read port A address
//   Ra_ena    in   read port A enable
//   Rb_adr    in   [N-1:0] read port B address
//   Rb_ena    in   read port B enable
//   Ra_data   out  [W-1:0] registered read data, port A (0 when disabled)
//   Rb_data   out  [W-1:0] registered read data, port B (0 when disabled)
//   Ra_valid  out  Ra_data valid
//   Rb_valid  out  Rb_data valid
//   Oea       out  [M-1:0] registered one-hot select, port A
//   Oeb       out  [M-1:0] registered one-hot select, port B
//   Wr_hit    out  an enabled port was served by the bypass last cycle
// ---------------------------------------------------------------------------
module regfile_2r1w_ctrl #(
  parameter int N        = 2,
  parameter int W        = 16,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [N-1:0]      W_adr,
  input  logic              W_ena,
  input  logic [W-1:0]      W_data,
  input  logic [N-1:0]      Ra_adr,
  input  logic              Ra_ena,
  input  logic [N-1:0]      Rb_adr,
  input  logic              Rb_ena,
  output logic [W-1:0]      Ra_data,
  output logic [W-1:0]      Rb_data,
  output logic              Ra_valid,
  output logic              Rb_valid,
  output logic [(1<<N)-1:0] Oea,
  output logic [(1<<N)-1:0] Oeb,
  output logic              Wr_hit
);

  localparam int M = 1 << N;

  logic [W-1:0] regs [M];

  logic         wr_commit_p0;
  logic         zero_a_p0;
  logic         zero_b_p0;
  logic         byp_a_p0;
  logic         byp_b_p0;
  logic [W-1:0] data_a_p0;
  logic [W-1:0] data_b_p0;

  // N-to-M one-hot read decoder.
  function automatic logic [M-1:0] decode(input logic [N-1:0] adr);
    logic [M-1:0] oh;
    oh      = '0;
    oh[adr] = 1'b1;
    return oh;
  endfunction

  // Address 0 is hard-wired to zero only when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [N-1:0] adr);
    return ZERO_REG && (adr == '0);
  endfunction

  // ---- stage p0: address compare, bypass and read mux ----
  assign wr_commit_p0 = W_ena && !is_zero_reg(W_adr);

  // The zero register wins over the bypass, so a write to r0 never
  // appears on a read port and never counts as a bypass hit.
  assign zero_a_p0 = is_zero_reg(Ra_adr);
  assign zero_b_p0 = is_zero_reg(Rb_adr);
  assign byp_a_p0  = !zero_a_p0 && W_ena && (W_adr == Ra_adr);
  assign byp_b_p0  = !zero_b_p0 && W_ena && (W_adr == Rb_adr);

  assign data_a_p0 = zero_a_p0 ? '0 : (byp_a_p0 ? W_data : regs[Ra_adr]);
  assign data_b_p0 = zero_b_p0 ? '0 : (byp_b_p0 ? W_data : regs[Rb_adr]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < M; i++) regs[i] <= '0;
    end else if (wr_commit_p0) begin
      regs[W_adr] <= W_data;
    end
  end

  // ---- stage p1: registered read outputs ----
  // A disabled port drives zeros rather than holding stale data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Ra_data  <= '0;
      Rb_data  <= '0;
      Ra_valid <= 1'b0;
      Rb_valid <= 1'b0;
      Oea      <= '0;
      Oeb      <= '0;
      Wr_hit   <= 1'b0;
    end else begin
      Ra_valid <= Ra_ena;
      Rb_valid <= Rb_ena;
      Oea      <= Ra_ena ? decode(Ra_adr) : '0;
      Oeb      <= Rb_ena ? decode(Rb_adr) : '0;
      Ra_data  <= Ra_ena ? data_a_p0 : '0;
      Rb_data  <= Rb_ena ? data_b_p0 : '0;
      Wr_hit   <= (Ra_ena && byp_a_p0) || (Rb_ena && byp_b_p0);
    end
  end

endmodule

// File: doc/regfile_2r1w_ctrl.md
Name: regfile_2r1w_ctrl

Overview:
- Parametrised register file: one synchronous write port and two independently enabled read ports (A, B).
- Each read port has an internal N-to-2**N one-hot read decoder and a registered data output.
- Same-cycle write-to-read bypass; optional hard-wired zero register.
- Sits between the instruction decoder and the datapath ALU. Replaces the stand-alone combinational read decoder plus external register bank.

Parameters:
- N, 2, address width; depth M = 2**N registers.
- W, 16, data width of each register.
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- W_adr  input  N  write address.
- W_ena  input  1  write enable.
- W_data  input  W  write data.
- Ra_adr  input  N  read port A address.
- Ra_ena  input  1  read port A enable.
- Rb_adr  input  N  read port B address.
- Rb_ena  input  1  read port B enable.
- Ra_data  output  W  registered read data, port A.
- Rb_data  output  W  registered read data, port B.
- Ra_valid  output  1  Ra_data valid this cycle.
- Rb_valid  output  1  Rb_data valid this cycle.
- Oea  output  M  registered one-hot select for the register read by A (0 when not enabled).
- Oeb  output  M  registered one-hot select for the register read by B (0 when not enabled).
- Wr_hit  output  1  registered flag: previous cycle's read on A or B was served by bypass.

Behaviour:
- Reset (Rst_n low, asynchronous, immediate effect):
  - All M registers = 0.
  - Ra_data = Rb_data = 0; Ra_valid = Rb_valid = 0; Oea = Oeb = 0; Wr_hit = 0.
  - Reset asserted mid-operation discards any in-flight write or read; no write commits on the edge where Rst_n is low.
- Write:
  - On rising Clk with W_ena = 1, reg[W_adr] <= W_data.
  - If ZERO_REG = 1 and W_adr = 0, the write is dropped.
  - W_ena = 0 leaves all registers unchanged.
- Read (per port, A shown; B identical and independent):
  - Latency 1 cycle. On rising Clk with Ra_ena = 1:
    - Ra_valid <= 1.
    - Oea <= 1 << Ra_adr.
    - Ra_data <= selected value.
  - Selected value priority:
    1. ZERO_REG = 1 and Ra_adr = 0: value is 0.
    2. W_ena = 1 and W_adr = Ra_adr: value is W_data (bypass, new data).
    3. Otherwise: value is reg[Ra_adr].
  - Ra_ena = 0: Ra_valid <= 0, Oea <= 0, Ra_data <= 0 (disabled port drives zero, never stale data).
- Wr_hit:
  - Wr_hit <= 1 if either enabled port took the bypass path in priority 2; otherwise 0.
  - A bypass suppressed by the ZERO_REG rule does not set Wr_hit.
- Simultaneous events:
  - A and B may read the same address in the same cycle; both get identical data and identical one-hot selects.
  - Write and two reads to the same address in one cycle: both ports return W_data.
- Widths: Oea and Oeb are exactly M bits. Addresses wrap naturally (all values 0..M-1 are legal); there is no out-of-range case.
- No combinational path from inputs to outputs; all outputs are flops.

Test Plan:
- Reset: drive arbitrary inputs, pulse Rst_n low between edges -> all outputs 0 immediately; reading regs 0..3 afterwards returns 0x0000.
- Basic write/read (N=2, W=16):
  - Write 0x1234 to r1, 0xBEEF to r3.
  - Next cycle: Ra_adr=1, Rb_adr=3, both enabled.
  - One edge later: Ra_data=0x1234, Rb_data=0xBEEF, Oea=4'b0010, Oeb=4'b1000, both valid=1, Wr_hit=0.
- Bypass: same cycle W_adr=2, W_data=0xA5A5, W_ena=1, Ra_adr=2, Ra_ena=1, Rb_adr=2, Rb_ena=1 -> next edge Ra_data=Rb_data=0xA5A5, Wr_hit=1; following read of r2 also 0xA5A5.
- Disable: Ra_ena=0, Rb_ena=1 reading r3 -> Ra_data=0, Ra_valid=0, Oea=0; Rb_data=0xBEEF, Oeb=4'b1000.
- ZERO_REG=1: write 0xFFFF to r0 while reading r0 on A -> Ra_data=0, Wr_hit=0, Oea=4'b0001; later read of r0 still 0.
- Reset mid-write: assert Rst_n low while W_ena=1, W_adr=1, W_data=0x5555 spans an edge; release -> r1 reads 0x0000.
